// File: rtl/uart_pkg.sv
// uart_pkg: types, default sizes and helpers shared by the UART transmitter and receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;

  // Even parity: XOR of all data bits (zero padding does not change the result).
  function automatic logic even_parity(input logic [31:0] d);
    return ^d;
  endfunction

  // Two-out-of-three vote used by the optional receive noise filter.
  function automatic logic majority3(input logic [2:0] w);
    return (w[0] & w[1]) | (w[0] & w[2]) | (w[1] & w[2]);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: brings the asynchronous rx line into the clk1 domain and produces
// the bit value used at every sample point.
// Optional macro UART_RX_MAJORITY_EN: sample points vote over the last three baud ticks.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk1,
  input  logic rst,
  input  logic baudTick_i,
  input  logic rx_i,
  output logic smp_o,
  output logic sample_o
);

  logic rxMeta_q;
  logic rxSync_q;

  // Two-flop synchroniser; both stages reset to the idle-high line level.
  always_ff @(posedge clk1) begin
    if (rst) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
    end else begin
      rxMeta_q <= rx_i;
      rxSync_q <= rxMeta_q;
    end
  end

  assign smp_o = rxSync_q;

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q;

  // Remember the two previous tick samples so the current one can be outvoted.
  always_ff @(posedge clk1) begin
    if (rst) begin
      hist_q <= 2'b11;
    end else if (baudTick_i) begin
      hist_q <= {hist_q[0], rxSync_q};
    end
  end

  assign sample_o = majority3({hist_q, rxSync_q});
`else
  logic unusedTick;
  assign unusedTick = baudTick_i;
  assign sample_o   = rxSync_q;
`endif

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: oversampled UART receiver (start, LSB-first data, even parity, stop)
// with a valid/ack output handshake and sticky overrun flag.
// Optional macro UART_RX_MAJORITY_EN: majority-of-three filtering at sample points.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int DATA_BITS  = UART_DATA_BITS
) (
  input  logic                 clk1,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 rx,
  input  logic                 ack,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic smp;
  logic sample;

  uart_rx_sync u_sync (
    .clk1       (clk1),
    .rst        (rst),
    .baudTick_i (baud_tick),
    .rx_i       (rx),
    .smp_o      (smp),
    .sample_o   (sample)
  );

  uart_state_e          state_q;
  logic [TW-1:0]        tickCnt_q;
  logic [BW-1:0]        bitCnt_q;
  logic [DATA_BITS-1:0] shiftReg_q;
  logic                 perr_q;
  logic                 armed_q;
  logic [DATA_BITS-1:0] dataOut_q;
  logic                 valid_q;
  logic                 parityErr_q;
  logic                 frameErr_q;
  logic                 overrun_q;

  // Frame FSM plus output handshake; frame completion is written after the ack
  // clear so a byte finishing in the ack cycle wins over the clear.
  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q     <= IDLE;
      tickCnt_q   <= '0;
      bitCnt_q    <= '0;
      shiftReg_q  <= '0;
      perr_q      <= 1'b0;
      armed_q     <= 1'b1;
      dataOut_q   <= '0;
      valid_q     <= 1'b0;
      parityErr_q <= 1'b0;
      frameErr_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (ack && valid_q) begin
        valid_q     <= 1'b0;
        parityErr_q <= 1'b0;
        frameErr_q  <= 1'b0;
        overrun_q   <= 1'b0;
      end
      if (baud_tick) begin
        case (state_q)
          IDLE: begin
            if (smp) begin
              armed_q <= 1'b1;
            end else if (armed_q) begin
              state_q   <= START;
              tickCnt_q <= '0;
            end
          end
          START: begin
            if (tickCnt_q == TICK_MID) begin
              tickCnt_q <= '0;
              bitCnt_q  <= '0;
              state_q   <= sample ? IDLE : DATA;
            end else begin
              tickCnt_q <= tickCnt_q + 1'b1;
            end
          end
          DATA: begin
            if (tickCnt_q == TICK_LAST) begin
              tickCnt_q  <= '0;
              shiftReg_q <= {sample, shiftReg_q[DATA_BITS-1:1]};
              if (bitCnt_q == BIT_LAST) begin
                state_q <= PARITY;
              end else begin
                bitCnt_q <= bitCnt_q + 1'b1;
              end
            end else begin
              tickCnt_q <= tickCnt_q + 1'b1;
            end
          end
          PARITY: begin
            if (tickCnt_q == TICK_LAST) begin
              tickCnt_q <= '0;
              perr_q    <= sample ^ even_parity(32'(shiftReg_q));
              state_q   <= STOP;
            end else begin
              tickCnt_q <= tickCnt_q + 1'b1;
            end
          end
          STOP: begin
            if (tickCnt_q == TICK_LAST) begin
              tickCnt_q <= '0;
              state_q   <= IDLE;
              if (!sample) begin
                armed_q <= 1'b0;
              end
              if (valid_q && !ack) begin
                overrun_q <= 1'b1;
              end else begin
                dataOut_q   <= shiftReg_q;
                parityErr_q <= perr_q;
                frameErr_q  <= ~sample;
                valid_q     <= 1'b1;
              end
            end else begin
              tickCnt_q <= tickCnt_q + 1'b1;
            end
          end
          default: begin
            state_q   <= IDLE;
            tickCnt_q <= '0;
          end
        endcase
      end
    end
  end

  assign data_out   = dataOut_q;
  assign valid      = valid_q;
  assign parity_err = parityErr_q;
  assign frame_err  = frameErr_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frames with hand-computed expected results for uart_receiver.
// baud_tick pulses on every second clk1 cycle; rx is driven in whole baud ticks.
module tb_uart_receiver;

  localparam int OS = 16;

  logic       clk1      = 1'b0;
  logic       rst       = 1'b1;
  logic       baud_tick = 1'b0;
  logic       rx        = 1'b1;
  logic       ack       = 1'b0;
  logic [7:0] data_out;
  logic       valid;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int   vectors     = 0;
  int   miscompares = 0;
  logic tickPhase   = 1'b0;
  logic busySeen;

  uart_receiver #(
    .OVERSAMPLE (OS),
    .DATA_BITS  (8)
  ) dut (
    .clk1       (clk1),
    .rst        (rst),
    .baud_tick  (baud_tick),
    .rx         (rx),
    .ack        (ack),
    .data_out   (data_out),
    .valid      (valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  // Free-running system clock.
  always #5 clk1 = ~clk1;

  // Baud enable on every other clk1 cycle, updated on the falling edge.
  always @(negedge clk1) begin
    tickPhase = ~tickPhase;
    baud_tick = tickPhase;
  end

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed no completion, required completion before time limit");
    $fatal(1, "[TB] time limit reached");
  end

  // Count one comparison and report it when observed differs from expected.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance n baud ticks and leave the bench 1 time unit past the last tick edge.
  task automatic waitTicks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk1);
      while (!baud_tick) @(posedge clk1);
    end
    #1;
  endtask

  // One bit period; optionally invert the line for the single tick seen at mid-bit.
  task automatic sendSlot(input logic v, input logic glitch);
    rx = v;
    if (glitch) begin
      waitTicks(8);
      rx = ~v;
      waitTicks(1);
      rx = v;
      waitTicks(7);
    end else begin
      waitTicks(OS);
    end
  endtask

  // Whole frame; ackAtStop raises ack for exactly the clk1 edge that samples the stop bit.
  task automatic applyStimulus(input logic [7:0] d, input logic parityBit, input logic stopBit,
                               input logic glitch, input logic ackAtStop);
    sendSlot(1'b0, glitch);
    for (int i = 0; i < 8; i++) sendSlot(d[i], glitch);
    sendSlot(parityBit, glitch);
    if (ackAtStop) begin
      rx = stopBit;
      waitTicks(9);
      @(posedge clk1);
      #1;
      ack = 1'b1;
      @(posedge clk1);
      #1;
      ack = 1'b0;
      waitTicks(6);
    end else begin
      sendSlot(stopBit, glitch);
    end
  endtask

  task automatic pulseAck();
    ack = 1'b1;
    @(posedge clk1);
    #1;
    ack = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "Data"},    32'(data_out),   32'h0);
    checkOutput({tag, "Valid"},   32'(valid),      32'h0);
    checkOutput({tag, "Parity"},  32'(parity_err), 32'h0);
    checkOutput({tag, "Frame"},   32'(frame_err),  32'h0);
    checkOutput({tag, "Overrun"}, 32'(overrun),    32'h0);
    checkOutput({tag, "Busy"},    32'(busy),       32'h0);
  endtask

  // Directed sequence: reset, good byte, parity error, break, glitch, overrun, mid-frame reset.
  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk1);
    #1;
    checkAllZero("rst");
    rst = 1'b0;
    waitTicks(4);

    applyStimulus(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("a5Data",    32'(data_out),   32'hA5);
    checkOutput("a5Valid",   32'(valid),      32'h1);
    checkOutput("a5Parity",  32'(parity_err), 32'h0);
    checkOutput("a5Frame",   32'(frame_err),  32'h0);
    checkOutput("a5Overrun", 32'(overrun),    32'h0);
    checkOutput("a5Busy",    32'(busy),       32'h0);
    pulseAck();
    checkOutput("a5AckValid", 32'(valid), 32'h0);
    checkOutput("a5AckData",  32'(data_out), 32'hA5);
    waitTicks(2);

    applyStimulus(8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("p01Data",   32'(data_out),   32'h01);
    checkOutput("p01Valid",  32'(valid),      32'h1);
    checkOutput("p01Parity", 32'(parity_err), 32'h1);
    checkOutput("p01Frame",  32'(frame_err),  32'h0);
    pulseAck();
    checkOutput("p01AckValid",  32'(valid),      32'h0);
    checkOutput("p01AckParity", 32'(parity_err), 32'h0);
    waitTicks(2);

    applyStimulus(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("brkData",   32'(data_out),   32'h3C);
    checkOutput("brkValid",  32'(valid),      32'h1);
    checkOutput("brkFrame",  32'(frame_err),  32'h1);
    checkOutput("brkParity", 32'(parity_err), 32'h0);
    busySeen = 1'b0;
    for (int i = 0; i < 20 * OS; i++) begin
      waitTicks(1);
      if (busy) busySeen = 1'b1;
    end
    checkOutput("brkBusy", 32'(busySeen), 32'h0);
    rx = 1'b1;
    waitTicks(OS);
    pulseAck();
    waitTicks(2);

    applyStimulus(8'h7E, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("7eData",   32'(data_out),   32'h7E);
    checkOutput("7eValid",  32'(valid),      32'h1);
    checkOutput("7eFrame",  32'(frame_err),  32'h0);
    checkOutput("7eParity", 32'(parity_err), 32'h0);
    pulseAck();
    waitTicks(2);

    rx = 1'b0;
    busySeen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      waitTicks(1);
      if (busy) busySeen = 1'b1;
    end
    rx = 1'b1;
    for (int i = 0; i < 12; i++) begin
      waitTicks(1);
      if (busy) busySeen = 1'b1;
    end
    waitTicks(4);
    checkOutput("glitchBusyPulse", 32'(busySeen), 32'h1);
    checkOutput("glitchBusyEnd",   32'(busy),     32'h0);
    checkOutput("glitchValid",     32'(valid),    32'h0);

    applyStimulus(8'h11, 1'b0, 1'b1, 1'b0, 1'b0);
    waitTicks(2);
    applyStimulus(8'h22, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("ovrData",    32'(data_out), 32'h11);
    checkOutput("ovrValid",   32'(valid),    32'h1);
    checkOutput("ovrOverrun", 32'(overrun),  32'h1);
    waitTicks(2);
    applyStimulus(8'h33, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("sameAckData",    32'(data_out), 32'h33);
    checkOutput("sameAckValid",   32'(valid),    32'h1);
    checkOutput("sameAckOverrun", 32'(overrun),  32'h0);
    waitTicks(2);

    sendSlot(1'b0, 1'b0);
    sendSlot(1'b1, 1'b0);
    sendSlot(1'b1, 1'b0);
    sendSlot(1'b0, 1'b0);
    rx = 1'b0;
    waitTicks(8);
    checkOutput("midBusy", 32'(busy), 32'h1);
    rst = 1'b1;
    @(posedge clk1);
    #1;
    checkAllZero("midRst");
    rst = 1'b0;
    rx  = 1'b1;
    waitTicks(4);

    applyStimulus(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("5aData",    32'(data_out),   32'h5A);
    checkOutput("5aValid",   32'(valid),      32'h1);
    checkOutput("5aParity",  32'(parity_err), 32'h0);
    checkOutput("5aFrame",   32'(frame_err),  32'h0);
    checkOutput("5aOverrun", 32'(overrun),    32'h0);
    pulseAck();
    waitTicks(2);

`ifdef UART_RX_MAJORITY_EN
    applyStimulus(8'h5A, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("majData",   32'(data_out),   32'h5A);
    checkOutput("majValid",  32'(valid),      32'h1);
    checkOutput("majParity", 32'(parity_err), 32'h0);
    checkOutput("majFrame",  32'(frame_err),  32'h0);
    pulseAck();
    waitTicks(2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
UART serial receiver; the stage directly downstream of the UART transmitter on the serial link. Recovers frames of 1 start bit (0), DATA_BITS data bits (LSB first), 1 even-parity bit (XOR of data bits) and 1 stop bit (1) from the asynchronous line rx. Oversamples rx using a baud_tick enable in the clk1 domain. Presents each byte with a valid/ack handshake and status flags.

Parameters:
OVERSAMPLE, 16, baud_tick pulses per bit period; even, at least 4
DATA_BITS, 8, data bits per frame

Ports:
clk1  in  1  system clock
rst  in  1  reset; synchronous, active-high
baud_tick  in  1  single-clk1-cycle enable at OVERSAMPLE x bit rate
rx  in  1  asynchronous serial line; idles high
ack  in  1  consumer has taken data_out; clears valid and flags
data_out  out  DATA_BITS  last received byte
valid  out  1  data_out holds an unread byte
parity_err  out  1  parity mismatch on the byte in data_out
frame_err  out  1  stop bit sampled 0 on the byte in data_out
overrun  out  1  sticky; a frame completed while valid was already 1
busy  out  1  1 whenever state != IDLE

Behaviour:
- Reset and clock: rst synchronous, active-high, clock clk1 (decided). Reset gives data_out=0, valid=0, parity_err=0, frame_err=0, overrun=0, busy=0, state IDLE, counters 0, synchroniser flops 1, armed=1. Reset mid-frame discards the partial frame.
- Input synchronisation: rx passes through a 2-flop synchroniser on every clk1 edge. smp = synchronised rx.
- State machine: IDLE, START, DATA, PARITY, STOP. The FSM and tick_cnt advance only on clk1 edges where baud_tick=1; otherwise all state holds.
- tick_cnt: width clog2(OVERSAMPLE). bit_cnt: width clog2(DATA_BITS).
- IDLE: if smp=1, set armed=1. If smp=0 and armed=1, go to START with tick_cnt=0.
- START: at tick_cnt=OVERSAMPLE/2-1, sample smp.
  - smp=1: glitch; return to IDLE.
  - smp=0: go to DATA with tick_cnt=0 and bit_cnt=0. Later samples then fall at mid-bit.
- DATA: at tick_cnt=OVERSAMPLE-1, shift smp into the MSB of shift_reg (LSB-first assembly) and increment bit_cnt. After bit DATA_BITS-1, go to PARITY.
- PARITY: at tick_cnt=OVERSAMPLE-1, record perr = smp XOR (^shift_reg). Go to STOP.
- STOP: at tick_cnt=OVERSAMPLE-1, go to IDLE. On the same edge: data_out<=shift_reg, parity_err<=perr, frame_err<=~smp, valid<=1. If smp=0, set armed=0; a held-low break line starts no new frame until rx has been seen high.
- tick_cnt wraps to 0 after OVERSAMPLE-1.
- Latency: valid rises on the clk1 edge of the baud_tick that samples the stop bit, about 10.5 bit times after the start edge.
- Handshake:
  - ack with valid=1 clears valid, parity_err, frame_err and overrun on the next edge. ack with valid=0 is ignored.
  - Frame completes while valid=1 and ack=0: overrun<=1; new byte and flags are discarded; data_out is kept.
  - Frame completes in the same cycle as ack: the new byte is loaded, valid stays 1, overrun=0.

Optional Feature:
UART_RX_MAJORITY_EN
- Defined: a 3-bit history of smp shifts on each baud_tick. Every sample point (start check, data, parity, stop) uses the majority of the last 3 ticks.
- Undefined: every sample point uses smp directly.
- IDLE start detection uses raw smp in both builds.

Decomposition:
- Shared package uart_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP)
  - default OVERSAMPLE and DATA_BITS constants
  - even-parity function shared with the transmitter
- One sub-module, uart_rx_sync: 2-flop synchroniser plus the optional majority filter. Output is the sample bit.

Test Plan:
- Frame 0xA5 (bits 1,0,1,0,0,1,0,1; parity 0; stop 1) at OVERSAMPLE=16 -> data_out=0xA5, valid=1, parity_err=0, frame_err=0. ack -> valid=0 next cycle.
- Frame 0x01 with parity bit 0 -> data_out=0x01, valid=1, parity_err=1.
- Frame 0x3C with stop bit 0, then rx held low for 20 bit times -> frame_err=1, busy stays 0 throughout the low period. Next clean frame 0x7E after rx high -> received correctly.
- rx low for 4 ticks, then high -> busy pulses, returns to IDLE, valid stays 0.
- Frames 0x11 then 0x22 with no ack -> data_out=0x11, overrun=1. Frame completing with ack in the same cycle -> new byte loaded, overrun=0.
- rst asserted during data bit 3 -> all outputs 0 next cycle. Following frame 0x5A -> data_out=0x5A, no errors. Repeat with UART_RX_MAJORITY_EN and a 1-tick glitch at each mid-bit -> byte unaffected.
